// File: rtl/adc_spi_reader.sv
// SPI master that reads one ADC frame (CPOL=1, sample on sclk rising) and presents the sample slice.
// Optional macro ADC_LEAD_CHECK_EN: flag frames whose leading bits are not all zero on frame_err.
module adc_spi_reader #(
    parameter int DATA_BITS    = 10,
    parameter int FRAME_BITS   = 16,
    parameter int LEAD_BITS    = 4,
    parameter int CLK_DIV      = 2,
    parameter int QUIET_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 reset_b,
    input  logic                 start,
    input  logic                 miso,
    output logic                 sclk,
    output logic                 cs_n,
    output logic                 busy,
    output logic [DATA_BITS-1:0] SPI_Data,
    output logic                 Bit_Count_Reached,
    output logic                 frame_err
);

    localparam int CNT_MAX = (CLK_DIV > QUIET_CYCLES) ? CLK_DIV : QUIET_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int BC_W    = $clog2(FRAME_BITS + 1);
    localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] QUIET_LAST = CNT_W'(QUIET_CYCLES - 1);
    localparam logic [BC_W-1:0]  EDGE_LAST  = BC_W'(FRAME_BITS - 1);
    localparam logic [BC_W-1:0]  KEEP_EDGES = BC_W'(LEAD_BITS + DATA_BITS);
`ifdef ADC_LEAD_CHECK_EN
    localparam int SR_W = LEAD_BITS + DATA_BITS;
`else
    // Leading bits simply fall off the top of a sample-wide register.
    localparam int SR_W = DATA_BITS;
`endif

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, DONE, QUIET} state_t;

    state_t            state, state_nx;
    logic [CNT_W-1:0]  cnt;
    logic [BC_W-1:0]   edge_cnt;
    logic [SR_W-1:0]   shreg;
    logic              cnt_last, rise;

    always_comb begin
        state_nx = state;
        cnt_last = (cnt == DIV_LAST);
        rise     = (state == SHIFT) && cnt_last && !sclk;
        case (state)
            IDLE:    if (start) state_nx = SETUP;
            SETUP:   if (cnt_last) state_nx = SHIFT;
            SHIFT:   if (rise && edge_cnt == EDGE_LAST) state_nx = DONE;
            DONE:    state_nx = QUIET;
            QUIET:   if (cnt == QUIET_LAST) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) state <= IDLE;
        else          state <= state_nx;
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            cnt               <= '0;
            edge_cnt          <= '0;
            shreg             <= '0;
            sclk              <= 1'b1;
            cs_n              <= 1'b1;
            busy              <= 1'b0;
            SPI_Data          <= '0;
            Bit_Count_Reached <= 1'b0;
        end else begin
            Bit_Count_Reached <= 1'b0;
            case (state)
                IDLE: begin
                    cnt      <= '0;
                    edge_cnt <= '0;
                    if (start) begin
                        cs_n <= 1'b0;
                        busy <= 1'b1;
                    end
                end
                SETUP, SHIFT: begin
                    cnt <= cnt_last ? '0 : cnt + CNT_W'(1);
                    // SETUP ends on a falling edge; the last SHIFT toggle leaves sclk high.
                    if (cnt_last) sclk <= ~sclk;
                    if (rise) begin
                        edge_cnt <= edge_cnt + BC_W'(1);
                        if (edge_cnt < KEEP_EDGES) shreg <= {shreg[SR_W-2:0], miso};
                    end
                end
                DONE: begin
                    SPI_Data          <= shreg[DATA_BITS-1:0];
                    Bit_Count_Reached <= 1'b1;
                    cs_n              <= 1'b1;
                    cnt               <= '0;
                end
                QUIET: begin
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == QUIET_LAST) busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

`ifdef ADC_LEAD_CHECK_EN
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b)           frame_err <= 1'b0;
        else if (state == DONE) frame_err <= |shreg[SR_W-1 -: LEAD_BITS];
    end
`else
    assign frame_err = 1'b0;
`endif

endmodule

// File: tb/tb_adc_spi_reader.sv
// Bench for adc_spi_reader: ADC slave model, timing-arithmetic reference model, per-cycle compare.
module tb_adc_spi_reader;
    localparam int DB = 10, FB = 16, LB = 4, CD = 2, QC = 4;
    localparam int SHIFT_END = 2 * FB * CD;     // last sclk rise, relative to accept
    localparam int STROBE_AT = SHIFT_END + 1;   // 65
    localparam int IDLE_AT   = STROBE_AT + QC;  // 69: busy low from here
    localparam int PERIOD    = IDLE_AT + 1;     // earliest next accept

    logic clk = 1'b0, reset_b = 1'b1, start = 1'b0, miso = 1'b0;
    logic sclk, cs_n, busy, strobe, frame_err;
    logic [DB-1:0] spi_data;

    adc_spi_reader dut (
        .clk(clk), .reset_b(reset_b), .start(start), .miso(miso),
        .sclk(sclk), .cs_n(cs_n), .busy(busy), .SPI_Data(spi_data),
        .Bit_Count_Reached(strobe), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ADC slave: latches a word when selected, shifts it out MSB first on sclk falls.
    logic [FB-1:0] next_word = '0, cur_word = '0;
    logic [FB-1:0] words[$];
    int bit_idx = 0, rise_cnt = 0;
    always @(negedge cs_n) begin
        cur_word = next_word;
        words.push_back(next_word);
        next_word = FB'($urandom);
        bit_idx = FB - 1;
        rise_cnt = 0;
    end
    always @(negedge sclk) if (cs_n === 1'b0 && bit_idx >= 0) begin
        miso = cur_word[bit_idx];
        bit_idx--;
    end
    always @(posedge sclk) if (cs_n === 1'b0) rise_cnt++;

    // Reference model: a frame is just an accept time; everything else is arithmetic on it.
    int cyc = 0, t0 = 0;
    bit active = 0;
    logic [DB-1:0] m_data = '0;
    logic m_err = 1'b0;
    always @(posedge clk) begin
        logic [FB-1:0] w;
        cyc++;
        if (!reset_b) active = 0;
        else begin
            if (start && (!active || cyc - t0 >= PERIOD)) begin
                active = 1;
                t0 = cyc;
            end else if (active && cyc - t0 >= PERIOD) active = 0;
            if (active && cyc - t0 == STROBE_AT) begin
                w = (words.size() > 0) ? words.pop_front() : 'x;
                m_data = w[FB-1-LB -: DB];
`ifdef ADC_LEAD_CHECK_EN
                m_err = (w[FB-1 -: LB] != 0);
`endif
            end
        end
    end
    always @(negedge reset_b) begin
        active = 0;
        m_data = '0;
        m_err  = 1'b0;
        words.delete();
    end

    int stb_cnt = 0, hi_run = 0, last_hi_run = 0;
    int stb_q[$];
    always @(negedge clk) begin
        int rel;
        bit on;
        rel = cyc - t0;
        on  = active && reset_b;
        chk("busy",   busy,   on && rel < IDLE_AT);
        chk("cs_n",   cs_n,   !(on && rel < STROBE_AT));
        chk("strobe", strobe, on && rel == STROBE_AT);
        chk("sclk",   sclk,   !(on && rel < SHIFT_END) || ((rel / CD) % 2 == 0));
        chk("data",   spi_data, m_data);
        chk("frame_err", frame_err, m_err);
        if (strobe === 1'b1) begin
            chk("sclk_rises", rise_cnt, FB);
            stb_cnt++;
            stb_q.push_back(cyc);
        end
        if (cs_n === 1'b1) hi_run++;
        else if (hi_run > 0) begin
            last_hi_run = hi_run;
            hi_run = 0;
        end
    end

    task automatic wait_to(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start_frame(output int tl);
        @(posedge clk);
        #2 start = 1'b1;
        @(posedge clk);
        #1 tl = cyc;
        start = 1'b0;
    endtask

    initial begin
        int tl, s0, nfr, off;
        #1 reset_b = 1'b0;
        #2;
        chk("rst_cs_n", cs_n, 1); chk("rst_sclk", sclk, 1); chk("rst_busy", busy, 0);
        chk("rst_data", spi_data, 0); chk("rst_strobe", strobe, 0); chk("rst_err", frame_err, 0);
        repeat (3) @(posedge clk);
        #3 reset_b = 1'b1;

        // 1: basic frame and its timing
        next_word = 16'b0000_1010100101_00;
        s0 = stb_cnt;
        start_frame(tl);
        chk("t1_cs_low", cs_n, 0); chk("t1_busy", busy, 1);
        wait_to(tl + 64); chk("t1_pre_strobe", strobe, 0);
        wait_to(tl + 65); chk("t1_strobe", strobe, 1);
        chk("t1_data", spi_data, 10'h2A5); chk("t1_model", m_data, 10'h2A5);
        wait_to(tl + 68); chk("t1_busy68", busy, 1);
        wait_to(tl + 69); chk("t1_busy69", busy, 0);
        chk("t1_count", stb_cnt - s0, 1);

        // 2: all-ones then all-zeros, held between strobes
        next_word = {4'b0, 10'h3FF, 2'b11};
        start_frame(tl);
        wait_to(tl + 66); chk("t2_ones", spi_data, 10'h3FF);
        wait_to(tl + 80); chk("t2_hold", spi_data, 10'h3FF);
        next_word = {4'b0, 10'h000, 2'b10};
        start_frame(tl);
        wait_to(tl + 64); chk("t2_hold_mid", spi_data, 10'h3FF);
        wait_to(tl + 66); chk("t2_zeros", spi_data, 10'h000);
        wait_to(tl + 75);

        // 3: start held for three frames
        s0 = stb_cnt;
        stb_q.delete();
        @(posedge clk);
        #2 start = 1'b1;
        @(posedge clk);
        #1 tl = cyc;
        wait_to(tl + 2 * PERIOD + 1);
        start = 1'b0;
        wait_to(tl + 3 * PERIOD + 5);
        chk("t3_count", stb_cnt - s0, 3);
        if (stb_q.size() == 3) begin
            chk("t3_space1", stb_q[1] - stb_q[0], 70);
            chk("t3_space2", stb_q[2] - stb_q[1], 70);
        end
        chk("t3_cs_gap", last_hi_run, QC + 1);

        // 4: start pulse mid-frame is dropped
        s0 = stb_cnt;
        start_frame(tl);
        wait_to(tl + 20);
        start = 1'b1;
        wait_to(tl + 21);
        start = 1'b0;
        wait_to(tl + PERIOD + 10);
        chk("t4_count", stb_cnt - s0, 1);
        chk("t4_idle", busy, 0);

        // 5: async reset mid-frame, then a clean frame
        chk("t5_prev_nonzero", spi_data != 0, 1);
        start_frame(tl);
        wait_to(tl + 30);
        #2 reset_b = 1'b0;
        #1;
        chk("t5_cs_n", cs_n, 1); chk("t5_sclk", sclk, 1); chk("t5_busy", busy, 0);
        chk("t5_data", spi_data, 0); chk("t5_strobe", strobe, 0);
        repeat (2) @(posedge clk);
        #3 reset_b = 1'b1;
        next_word = 16'b0000_0110011001_01;
        start_frame(tl);
        wait_to(tl + 65); chk("t5_strobe_after", strobe, 1); chk("t5_clean", spi_data, 10'h199);
        wait_to(tl + 75);

        // 6: non-zero leading bits
        next_word = {4'b0100, 10'h155, 2'b00};
        start_frame(tl);
        wait_to(tl + 65);
        chk("t6_data", spi_data, 10'h155);
`ifdef ADC_LEAD_CHECK_EN
        chk("t6_err", frame_err, 1);
`else
        chk("t6_err", frame_err, 0);
`endif
        wait_to(tl + 75);
        next_word = {4'b0000, 10'h0AA, 2'b11};
        start_frame(tl);
        wait_to(tl + 65);
        chk("t6_err_clear", frame_err, 0); chk("t6_data2", spi_data, 10'h0AA);
        wait_to(tl + 75);

        // random frames with stray start pulses and random gaps
        s0 = stb_cnt;
        nfr = 0;
        repeat (20) begin
            next_word = FB'($urandom);
            if ($urandom_range(0, 1) == 1) next_word[FB-1 -: LB] = '0;
            start_frame(tl);
            nfr++;
            if ($urandom_range(0, 1) == 1) begin
                off = $urandom_range(1, 60);
                wait_to(tl + off);
                start = 1'b1;
                wait_to(tl + off + 1);
                start = 1'b0;
            end
            wait_to(tl + PERIOD + $urandom_range(0, 5));
        end
        wait_to(cyc + 3);
        chk("rand_count", stb_cnt - s0, nfr);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
